// File: rtl/ibram_bank_arbiter_if.sv
// Requester and bank-side bus of the IB-RAM bank arbiter. The master side is
// the environment: the decoder lanes plus the IB-RAM macro that returns read data.
interface ibram_bank_arbiter_if #(
  parameter int REQ_NUM         = 4,
  parameter int ADDR_WIDTH      = 8,
  parameter int BANK_NUM        = 4,
  parameter int PAGE_ADDR_WIDTH = 6,
  parameter int PAGE_SIZE       = 4
);
  logic [REQ_NUM-1:0]                  req_valid;
  logic [REQ_NUM*ADDR_WIDTH-1:0]       req_addr;
  logic [REQ_NUM-1:0]                  req_ready;
  logic [REQ_NUM-1:0]                  rsp_valid;
  logic [REQ_NUM*PAGE_SIZE-1:0]        rsp_data;
  logic [BANK_NUM-1:0]                 bank_rd_en;
  logic [BANK_NUM*PAGE_ADDR_WIDTH-1:0] bank_page_addr;
  logic [BANK_NUM*PAGE_SIZE-1:0]       bank_rdata;

  modport master (
    output req_valid, req_addr, bank_rdata,
    input  req_ready, rsp_valid, rsp_data, bank_rd_en, bank_page_addr
  );

  modport slave (
    input  req_valid, req_addr, bank_rdata,
    output req_ready, rsp_valid, rsp_data, bank_rd_en, bank_page_addr
  );
endinterface

// File: rtl/ibram_bank_arbiter.sv
// Per-bank round-robin arbiter and read sequencer for the banked IB-RAM LUT macro.
// Optional feature: define IBRAM_ARB_RSP_REG_EN to add an output register on rsp_valid/rsp_data.
module ibram_bank_arbiter #(
  parameter int REQ_NUM              = 4,
  parameter int BANK_INTERLEAVE_TYPE = 0,
  parameter int BANK_NUM             = 4,
  parameter int ADDR_WIDTH           = 8,
  parameter int BANK_ADDR_WIDTH      = 2,
  parameter int PAGE_ADDR_WIDTH      = 6,
  parameter int PAGE_SIZE            = 4,
  parameter int ASYNC_RD_EN          = 1
) (
  input  logic                      sys_clk,
  input  logic                      rstn,
  ibram_bank_arbiter_if.slave       bus,
  input  logic                      stat_clr,
  output logic [15:0]               conflict_cnt
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [BANK_ADDR_WIDTH-1:0] req_bank  [REQ_NUM];
  logic [PAGE_ADDR_WIDTH-1:0] req_page  [REQ_NUM];
  logic [PAGE_SIZE-1:0]       bank_word [BANK_NUM];
  logic                       grant_vld [BANK_NUM];
  logic [PTR_W-1:0]           grant_idx [BANK_NUM];
  logic [REQ_NUM-1:0]         accept;
  logic [REQ_NUM-1:0]         rsp_valid_int;
  logic [REQ_NUM*PAGE_SIZE-1:0] rsp_data_int;
  logic [15:0]                conflict_cnt_reg;
  logic                       conflict_any;

  genvar gi;

  // Bank side: round-robin search per bank, then drive that bank's read port.
  generate
    for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
      logic             vld;
      logic [PTR_W-1:0] sel;
      logic [PTR_W-1:0] cidx;
      logic [PTR_W-1:0] rr_ptr_reg;
      logic [PTR_W-1:0] rr_ptr_next;
      int               cand;

      always_comb begin
        vld  = 1'b0;
        sel  = '0;
        cand = 0;
        cidx = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
          cand = int'(rr_ptr_reg) + k;
          if (cand >= REQ_NUM) cand = cand - REQ_NUM;
          cidx = PTR_W'(cand);
          if (!vld && bus.req_valid[cidx] && (req_bank[cidx] == BANK_ADDR_WIDTH'(gi))) begin
            vld = 1'b1;
            sel = cidx;
          end
        end
        // Nothing is granted while reset is held, so no read reaches the macro.
        if (!rstn) vld = 1'b0;
      end

      assign rr_ptr_next = (sel == PTR_W'(REQ_NUM - 1)) ? '0 : sel + PTR_W'(1);

      always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn)    rr_ptr_reg <= '0;
        else if (vld) rr_ptr_reg <= rr_ptr_next;
      end

      assign grant_vld[gi] = vld;
      assign grant_idx[gi] = sel;
      assign bank_word[gi] = bus.bank_rdata[gi*PAGE_SIZE +: PAGE_SIZE];
      assign bus.bank_rd_en[gi] = vld;
      assign bus.bank_page_addr[gi*PAGE_ADDR_WIDTH +: PAGE_ADDR_WIDTH] = vld ? req_page[sel] : '0;
    end
  endgenerate

  // Requester side: address decode, grant collection and the response path.
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_req
      logic [ADDR_WIDTH-1:0] addr;
      logic                  hit;

      assign addr = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      if (BANK_INTERLEAVE_TYPE == 0) begin : g_bank_hi
        assign req_bank[gi] = addr[ADDR_WIDTH-1 -: BANK_ADDR_WIDTH];
        assign req_page[gi] = addr[PAGE_ADDR_WIDTH-1:0];
      end else begin : g_bank_lo
        assign req_bank[gi] = addr[BANK_ADDR_WIDTH-1:0];
        assign req_page[gi] = addr[ADDR_WIDTH-1 -: PAGE_ADDR_WIDTH];
      end

      always_comb begin
        hit = 1'b0;
        for (int b = 0; b < BANK_NUM; b++) begin
          if (grant_vld[b] && (grant_idx[b] == PTR_W'(gi))) hit = 1'b1;
        end
      end

      assign accept[gi]        = hit;
      assign bus.req_ready[gi] = hit;

      if (ASYNC_RD_EN != 0) begin : g_async
        logic                 valid_reg;
        logic [PAGE_SIZE-1:0] data_reg;

        // Macro data is already valid in the grant cycle, so capture it there.
        always_ff @(posedge sys_clk or negedge rstn) begin
          if (!rstn) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
          end else begin
            valid_reg <= hit;
            data_reg  <= hit ? bank_word[req_bank[gi]] : '0;
          end
        end

        assign rsp_valid_int[gi] = valid_reg;
        assign rsp_data_int[gi*PAGE_SIZE +: PAGE_SIZE] = data_reg;
      end else begin : g_sync
        logic                       valid_reg;
        logic [BANK_ADDR_WIDTH-1:0] tag_reg;

        // Macro data arrives a cycle late; the tag selects which bank to forward.
        always_ff @(posedge sys_clk or negedge rstn) begin
          if (!rstn) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
          end else begin
            valid_reg <= hit;
            if (hit) tag_reg <= req_bank[gi];
          end
        end

        assign rsp_valid_int[gi] = valid_reg;
        assign rsp_data_int[gi*PAGE_SIZE +: PAGE_SIZE] = valid_reg ? bank_word[tag_reg] : '0;
      end
    end
  endgenerate

`ifdef IBRAM_ARB_RSP_REG_EN
  logic [REQ_NUM-1:0]           rsp_valid_q_reg;
  logic [REQ_NUM*PAGE_SIZE-1:0] rsp_data_q_reg;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q_reg <= '0;
      rsp_data_q_reg  <= '0;
    end else begin
      rsp_valid_q_reg <= rsp_valid_int;
      rsp_data_q_reg  <= rsp_data_int;
    end
  end

  assign bus.rsp_valid = rsp_valid_q_reg;
  assign bus.rsp_data  = rsp_data_q_reg;
`else
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_data_int;
`endif

  assign conflict_any = |(bus.req_valid & ~accept);

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)                                          conflict_cnt_reg <= '0;
    else if (stat_clr)                                  conflict_cnt_reg <= '0;
    else if (conflict_any && (conflict_cnt_reg != 16'hFFFF)) conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
  end

  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: doc/ibram_bank_arbiter.md
# ibram_bank_arbiter

Per-bank round-robin arbiter and read sequencer that lets `REQ_NUM` requesters (CNU/VNU lookup lanes) share one bank-interleaved IB-RAM macro holding the quantised IB LUTs. Each cycle it decodes every request address into `{bank, page}`, grants at most one requester per bank, drives the banks' read enables and page addresses, and routes the returned page data back to the granted requester. It sits between the decoder lanes and the IB-RAM banks, and supports both the two-bank and four-bank Q4 configurations.

## Interface
- `REQ_NUM`, 4, number of requesters (≥2)
- `BANK_INTERLEAVE_TYPE`, 0, 0: addr = {bank, page}; 1: addr = {page, bank}
- `BANK_NUM`, 4, number of interleaved banks (power of 2)
- `ADDR_WIDTH`, 8, request address width = `BANK_ADDR_WIDTH` + `PAGE_ADDR_WIDTH`
- `BANK_ADDR_WIDTH`, 2, $clog2(`BANK_NUM`)
- `PAGE_ADDR_WIDTH`, 6, page address width
- `PAGE_SIZE`, 4, bits per page (read word per bank)
- `ASYNC_RD_EN`, 1, 1: bank data valid in the same cycle as `bank_rd_en`; 0: bank data valid one cycle later
- `sys_clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `req_valid`  in  `REQ_NUM`  request valid per requester
- `req_addr`  in  `REQ_NUM*ADDR_WIDTH`  request address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_ready`  out  `REQ_NUM`  grant; a request is accepted on a cycle where valid and ready are both 1
- `rsp_valid`  out  `REQ_NUM`  response valid per requester
- `rsp_data`  out  `REQ_NUM*PAGE_SIZE`  response page data per requester
- `bank_rd_en`  out  `BANK_NUM`  read enable per bank
- `bank_page_addr`  out  `BANK_NUM*PAGE_ADDR_WIDTH`  page address per bank
- `bank_rdata`  in  `BANK_NUM*PAGE_SIZE`  read data per bank
- `stat_clr`  in  1  synchronous clear of `conflict_cnt`
- `conflict_cnt`  out  16  saturating count of conflict cycles

## Operation
- Decode, type 0: bank = addr[ADDR_WIDTH-1 -: BANK_ADDR_WIDTH], page = low `PAGE_ADDR_WIDTH` bits. Type 1: bank = addr[BANK_ADDR_WIDTH-1:0], page = high bits.
- Each bank has its own round-robin pointer `rr_ptr[b]` (width $clog2(REQ_NUM), reset 0).
- Grant rule: among valid requesters targeting bank b, the first one found searching upward from `rr_ptr[b]` (with wrap) is granted.
- On a grant to requester i, `rr_ptr[b]` becomes (i+1) mod `REQ_NUM`. The pointer holds when the bank has no grant.
- `req_ready` is combinational from `req_valid`/`req_addr` and the pointers. A requester that is not granted must hold valid and address stable.
- `bank_rd_en[b]` = 1 whenever bank b has a grant. `bank_page_addr[b]` = the granted page; it is 0 when the bank is idle.
- The response tag (requester → bank) is registered on acceptance.
  - `ASYNC_RD_EN=1`: `bank_rdata` is captured into the response register in the acceptance cycle.
  - `ASYNC_RD_EN=0`: `rsp_data` is muxed from `bank_rdata` using the registered tag.
- `rsp_data` for a non-valid lane is 0.
- `conflict_cnt`:
  - Increments by 1 on each cycle in which at least one valid request is not granted.
  - Saturates at 0xFFFF.
  - `stat_clr` has priority over increment; the count reads 0 on the next cycle.
- Reset (asynchronous assert, synchronous deassert assumed upstream) clears all pointers, tags, `rsp_valid`, `rsp_data` and `conflict_cnt`. In-flight reads are dropped, with no response after release.

## Timing
- Reset values: `req_ready` = 0 while `rstn` = 0; `rsp_valid` = 0; `rsp_data` = 0; `bank_rd_en` = 0; `bank_page_addr` = 0; `conflict_cnt` = 0.
- Grant latency: 0 cycles; `req_ready` is in the same cycle as `req_valid` when there is no conflict.
- Response latency: `rsp_valid` is asserted exactly 1 cycle after acceptance, for 1 cycle, for either `ASYNC_RD_EN` value.
- Throughput: 1 request per bank per cycle. Worst case, all requesters on one bank, each requester waits at most `REQ_NUM`-1 cycles.
- Simultaneous acceptance and response on the same lane is allowed: a back-to-back grant gives `rsp_valid` on consecutive cycles.

## Configuration
- `IBRAM_ARB_RSP_REG_EN` defined: an extra output register stage is added on `rsp_valid`/`rsp_data`. Response latency becomes 2 cycles; reset value is 0.
- `IBRAM_ARB_RSP_REG_EN` undefined: response latency is 1 cycle, as specified above.

## Test plan
Defaults apply (`REQ_NUM`=4, `BANK_NUM`=4, type 0, `ASYNC_RD_EN`=1, macro undefined).
- Requesters 0–3 send addrs 0x00, 0x45, 0x8A, 0xCF in the same cycle → all `req_ready` = 1; `bank_page_addr` = {0x0F, 0x0A, 0x05, 0x00} for banks 3..0; all `rsp_valid` = 1 next cycle with the matching bank data; `conflict_cnt` = 0.
- All four requesters hold addrs 0x01..0x04 (bank 0) → grants to requesters 0, 1, 2, 3 on consecutive cycles; each `rsp_valid` follows 1 cycle later; `conflict_cnt` = 3.
- Requesters 0 and 2 hold valid continuously on bank 1 (0x41, 0x42) → grants alternate 0, 2, 0, 2; `conflict_cnt` increments every cycle.
- `BANK_INTERLEAVE_TYPE`=1, `ASYNC_RD_EN`=0: addr 0x05 → `bank_rd_en[1]`, page 0x01; `rsp_data` equals bank 1's `bank_rdata` from the following cycle, with `rsp_valid` on that cycle.
- Accept on requester 3, then `rstn` = 0 the next cycle → `rsp_valid` = 0 immediately; no response after release; the next bank-0 conflict grants requester 0 first.
- Hold a conflict for 70000 cycles → `conflict_cnt` = 0xFFFF and held; pulse `stat_clr` → 0 next cycle; with the macro defined, response latency measures 2 cycles.
